// File: rtl/uart_tx_arbiter_pkg.sv
// uart_pkg: definitions shared by the UART TX arbiter and the TX FIFO controller
// (FSM state encoding, byte width, index-width helper).
package uart_pkg;

    localparam int UART_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SETTLE = 2'd2
    } uart_state_e;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int unsigned uart_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte handshake plus TX FIFO write side.
// master = requesters/FIFO side, slave = arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = UART_DW
);
    localparam int unsigned GW = uart_idx_w(N_REQ);

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_last;
    logic                full;
    logic                winc;
    logic [DW-1:0]       wdata;
    logic [N_REQ-1:0]    ack;
    logic [GW-1:0]       grant_id;

    modport master (
        output req, req_data, req_last, full,
        input  winc, wdata, ack, grant_id
    );

    modport slave (
        input  req, req_data, req_last, full,
        output winc, wdata, ack, grant_id
    );

endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational rotating-priority picker; the first set request
// at or above start (with wrap) wins.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter  int          N_REQ = 4,
    localparam int unsigned GW    = uart_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    start,
    output logic [N_REQ-1:0] grant_oh,
    output logic [GW-1:0]    grant_idx,
    output logic             any
);

    logic [GW-1:0] k;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        k         = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = GW'((32'(start) + i) % N_REQ);
            if (!any && req[k]) begin
                any         = 1'b1;
                grant_oh[k] = 1'b1;
                grant_idx   = k;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing the UART TX FIFO write port.
// Optional message lock enabled by defining UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DW       = UART_DW,
    parameter int LOCK_TMO = 255
) (
    input logic               clock,
    input logic               rst_n,
    uart_tx_arbiter_if.slave  bus
);

    localparam int unsigned GW = uart_idx_w(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || LOCK_TMO < 1) begin : g_param_check
        $error("uart_tx_arbiter: N_REQ must be 2..8 and LOCK_TMO >= 1");
    end

    uart_state_e      state;
    logic             winc_q;
    logic [DW-1:0]    wdata_q;
    logic [N_REQ-1:0] ack_q;
    logic [GW-1:0]    grant_id_q;

    logic [GW-1:0]    start_idx;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] pick_oh;
    logic [GW-1:0]    pick_idx;
    logic             pick_any;
    logic [DW-1:0]    pick_data;

    assign start_idx = (grant_id_q == GW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    assign pick_data = bus.req_data[pick_idx*DW +: DW];

`ifdef UART_TX_ARB_LOCK_EN
    localparam int unsigned CW = $clog2(LOCK_TMO + 1);

    logic             locked;
    logic [CW-1:0]    lock_cnt;
    logic [N_REQ-1:0] own_mask;

    // While locked only the owner (last granted requester) is eligible.
    assign own_mask = N_REQ'(1) << grant_id_q;
    assign elig     = locked ? (bus.req & own_mask) : bus.req;
`else
    logic req_last_unused;

    assign req_last_unused = ^bus.req_last;
    assign elig            = bus.req;
`endif

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req       (elig),
        .start     (start_idx),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // SETTLE arbitrates exactly like IDLE: the FIFO full flag already reflects
    // the write from the previous cycle, which gives one byte per two cycles.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            winc_q     <= 1'b0;
            wdata_q    <= '0;
            ack_q      <= '0;
            grant_id_q <= GW'(N_REQ - 1);
`ifdef UART_TX_ARB_LOCK_EN
            locked     <= 1'b0;
            lock_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE, SETTLE: begin
                    if (pick_any && !bus.full) begin
                        winc_q     <= 1'b1;
                        wdata_q    <= pick_data;
                        ack_q      <= pick_oh;
                        grant_id_q <= pick_idx;
                        state      <= WRITE;
`ifdef UART_TX_ARB_LOCK_EN
                        locked     <= !bus.req_last[pick_idx];
                        lock_cnt   <= '0;
`endif
                    end else begin
                        winc_q  <= 1'b0;
                        wdata_q <= '0;
                        ack_q   <= '0;
                        state   <= IDLE;
`ifdef UART_TX_ARB_LOCK_EN
                        if (locked && !bus.req[grant_id_q] && !bus.full) begin
                            if (lock_cnt == CW'(LOCK_TMO - 1)) begin
                                locked   <= 1'b0;
                                lock_cnt <= '0;
                            end else begin
                                lock_cnt <= lock_cnt + 1'b1;
                            end
                        end
`endif
                    end
                end
                WRITE: begin
                    winc_q  <= 1'b0;
                    wdata_q <= '0;
                    ack_q   <= '0;
                    state   <= SETTLE;
                end
                default: begin
                    winc_q  <= 1'b0;
                    wdata_q <= '0;
                    ack_q   <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.winc     = winc_q;
    assign bus.wdata    = wdata_q;
    assign bus.ack      = ack_q;
    assign bus.grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter (N_REQ=4, DW=8).
// Lock scenario runs only when UART_TX_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

    logic clock;
    logic rst_n;
    int   checks;
    int   errors;

    uart_tx_arbiter_if #(.N_REQ(4), .DW(8)) bus ();

    uart_tx_arbiter #(
        .N_REQ    (4),
        .DW       (8),
        .LOCK_TMO (16)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input string tag, input logic [7:0] d, input logic [3:0] a,
                               input logic [1:0] g);
        check({tag, "_winc"}, 32'(bus.winc), 32'd1);
        check({tag, "_wdata"}, 32'(bus.wdata), 32'(d));
        check({tag, "_ack"}, 32'(bus.ack), 32'(a));
        check({tag, "_gid"}, 32'(bus.grant_id), 32'(g));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_winc"}, 32'(bus.winc), 32'd0);
        check({tag, "_ack"}, 32'(bus.ack), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_data [5];
        logic [3:0] exp_ack  [5];
        int         first_hit;

        checks = 0;
        errors = 0;
        exp_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        exp_ack  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_n        = 1'b0;
        bus.req      = '0;
        bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.req_last = '0;
        bus.full     = 1'b0;
        repeat (3) step();

        // reset values
        check_quiet("rst");
        check("rst_wdata", 32'(bus.wdata), 32'd0);
        check("rst_gid", 32'(bus.grant_id), 32'd3);
        rst_n = 1'b1;
        step();
        check_quiet("post_rst");

        // all four requesting: round robin from req[0], one byte per two cycles
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check_write("rr", exp_data[i], exp_ack[i], 2'(i % 4));
            if (i == 4) bus.req = '0;
            step();
            check_quiet("rr_settle");
        end
        step();
        check_quiet("rr_idle");

        // single request: one-cycle latency
        bus.req = 4'b0100;
        step();
        check_write("lat", 8'hA2, 4'b0100, 2'd2);
        bus.req = '0;
        step();
        check_quiet("lat_settle");
        step();
        check_quiet("lat_idle");

        // full holds off all writes; release grants req[0] first
        bus.full = 1'b1;
        bus.req  = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            step();
            check("full_hold_winc", 32'(bus.winc), 32'd0);
        end
        bus.full = 1'b0;
        step();
        check_write("full_rel", 8'hA0, 4'b0001, 2'd0);
        bus.req = '0;
        step();
        step();

        // full rising during the write cycle: byte goes out, next grant waits
        bus.req = 4'b0011;
        step();
        check_write("full_wr", 8'hA1, 4'b0010, 2'd1);
        bus.full = 1'b1;
        step();
        check_quiet("full_wr_settle");
        repeat (3) step();
        check_quiet("full_wr_wait");
        bus.full = 1'b0;
        step();
        check_write("full_wr_next", 8'hA0, 4'b0001, 2'd0);
        bus.req = '0;
        step();
        step();

`ifdef UART_TX_ARB_LOCK_EN
        // message lock: req[1] two-byte message is not interleaved with req[0]
        bus.req_data = {8'hA3, 8'hA2, 8'h48, 8'h30};
        bus.req_last = 4'b0001;
        bus.req      = 4'b0011;
        step();
        check_write("lock_b0", 8'h48, 4'b0010, 2'd1);
        bus.req_data[15:8] = 8'h49;
        bus.req_last[1]    = 1'b1;
        step();
        check_quiet("lock_s0");
        step();
        check_write("lock_b1", 8'h49, 4'b0010, 2'd1);
        bus.req_data[15:8] = 8'h4A;
        bus.req_last[1]    = 1'b0;
        step();
        check_quiet("lock_s1");
        step();
        check_write("lock_r0", 8'h30, 4'b0001, 2'd0);
        step();
        step();
        check_write("lock_b2", 8'h4A, 4'b0010, 2'd1);
        // req[1] stalls mid-message: 16 counted cycles release the lock
        bus.req[1] = 1'b0;
        first_hit = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (first_hit == 0 && bus.winc === 1'b1) begin
                first_hit = n;
                check("lock_tmo_wdata", 32'(bus.wdata), 32'h30);
                check("lock_tmo_ack", 32'(bus.ack), 32'b0001);
            end
        end
        check("lock_tmo_cycle", 32'(first_hit), 32'd18);
        bus.req      = '0;
        bus.req_last = '0;
        bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        step();
        step();
`endif

        // reset during the write cycle drops the pulse immediately
        bus.req = 4'b1111;
        step();
        check_write("mid_wr", 8'hA1, 4'b0010, 2'd1);
        #1 rst_n = 1'b0;
        #1;
        check_quiet("mid_rst");
        check("mid_rst_wdata", 32'(bus.wdata), 32'd0);
        check("mid_rst_gid", 32'(bus.grant_id), 32'd3);
        bus.req = '0;
        step();
        rst_n = 1'b1;
        step();
        check_quiet("mid_rst_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
